// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the MEM-stage SRAM controller.
package sram_ctrl_pkg;

  localparam int unsigned SRAM_AW          = 18;
  localparam int unsigned SRAM_DW          = 16;
  localparam int unsigned WORD_AW          = SRAM_AW - 1;
  localparam int unsigned BUS_W            = 32;
  localparam int unsigned DEF_BASE_ADDR    = 1024;
  localparam int unsigned DEF_PHASE_CYCLES = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_e;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;

  // Latched copy of a request, held for the whole access
  typedef struct packed {
    op_e                op;
    logic [WORD_AW-1:0] word;
    logic [BUS_W-1:0]   data;
  } req_t;

  // Byte address to SRAM word index; addresses below base wrap around
  function automatic logic [WORD_AW-1:0] word_of(input logic [BUS_W-1:0] addr,
                                                 input logic [BUS_W-1:0] base);
    logic [BUS_W-1:0] offset;
    offset = addr - base;
    return WORD_AW'(offset >> 2);
  endfunction

endpackage

// File: rtl/sram_controller_if.sv
// Pipeline-side load/store handshake between the MEM stage and the controller.
interface sram_controller_if;
  import sram_ctrl_pkg::*;

  logic             wr_en;
  logic             rd_en;
  logic [BUS_W-1:0] address;
  logic [BUS_W-1:0] write_data;
  logic [BUS_W-1:0] read_data;
  logic             ready;

  modport master (
    output wr_en, rd_en, address, write_data,
    input  read_data, ready
  );

  modport slave (
    input  wr_en, rd_en, address, write_data,
    output read_data, ready
  );
endinterface

// File: rtl/sram_dq_io.sv
// SRAM data-bus tri-state driver and half-word read capture.
module sram_dq_io
  import sram_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               drive_en_d,
  input  logic [SRAM_DW-1:0] drive_data_d,
  input  logic               cap_lo,
  input  logic               cap_hi,
  input  logic               fwd_load,
  input  logic [BUS_W-1:0]   fwd_data,
  output logic [BUS_W-1:0]   read_data,
  inout  wire  [SRAM_DW-1:0] dq
);

  logic               drive_en_q;
  logic [SRAM_DW-1:0] drive_data_q;
  logic [SRAM_DW-1:0] lo_q;

  assign dq = drive_en_q ? drive_data_q : {SRAM_DW{1'bz}};

  // Registered bus drive; low half is staged so read_data only changes when a load finishes
  always_ff @(posedge clk) begin
    if (rst) begin
      drive_en_q   <= 1'b0;
      drive_data_q <= '0;
      lo_q         <= '0;
      read_data    <= '0;
    end else begin
      drive_en_q   <= drive_en_d;
      drive_data_q <= drive_data_d;
      if (cap_lo) begin
        lo_q <= dq;
      end
      if (cap_hi) begin
        read_data <= {dq, lo_q};
      end else if (fwd_load) begin
        read_data <= fwd_data;
      end
    end
  end

endmodule

// File: rtl/sram_controller.sv
// Splits 32-bit MEM-stage loads/stores into two 16-bit SRAM phases (low, then high).
// Optional last-write forwarding is enabled by defining SRAM_CTRL_FORWARD_EN.
module sram_controller
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned BASE_ADDR    = DEF_BASE_ADDR,
  parameter int unsigned PHASE_CYCLES = DEF_PHASE_CYCLES
) (
  input  logic               clk,
  input  logic               rst,
  sram_controller_if.slave   bus,
  inout  wire  [SRAM_DW-1:0] SRAM_DQ,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  output logic               SRAM_UB_N,
  output logic               SRAM_LB_N,
  output logic               SRAM_CE_N,
  output logic               SRAM_OE_N,
  output logic               SRAM_WE_N
);

  localparam int unsigned      CNT_W    = (PHASE_CYCLES > 2) ? $clog2(PHASE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PHASE_CYCLES - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  req_t               req_q, req_d;
  logic [SRAM_AW-1:0] addr_d;
  logic               we_n_d;
  logic               drive_en_d;
  logic [SRAM_DW-1:0] drive_data_d;
  logic               req_c;
  logic               phase_end;
  logic               cap_lo;
  logic               cap_hi;
  logic               fwd_hit;
  logic               fwd_load;
  logic [BUS_W-1:0]   fwd_data;
  logic [WORD_AW-1:0] word_c;

  assign req_c     = bus.wr_en | bus.rd_en;
  assign word_c    = word_of(bus.address, BUS_W'(BASE_ADDR));
  assign phase_end = (cnt_q == CNT_LAST);

  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_OE_N = 1'b0;

`ifdef SRAM_CTRL_FORWARD_EN
  logic               fwd_valid_q;
  logic [WORD_AW-1:0] fwd_word_q;
  logic [BUS_W-1:0]   fwd_data_q;

  // Remember the last completed store so a matching load can bypass the SRAM
  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_valid_q <= 1'b0;
      fwd_word_q  <= '0;
      fwd_data_q  <= '0;
    end else if ((state_q == HI) && phase_end && (req_q.op == OP_WRITE)) begin
      fwd_valid_q <= 1'b1;
      fwd_word_q  <= req_q.word;
      fwd_data_q  <= req_q.data;
    end
  end

  assign fwd_hit  = bus.rd_en & ~bus.wr_en & fwd_valid_q & (fwd_word_q == word_c);
  assign fwd_data = fwd_data_q;
`else
  assign fwd_hit  = 1'b0;
  assign fwd_data = '0;
`endif

  assign fwd_load = (state_q == IDLE) & fwd_hit;

  // Read capture at the edge closing the last cycle of each phase
  assign cap_lo = (state_q == LO) & phase_end & (req_q.op == OP_READ);
  assign cap_hi = (state_q == HI) & phase_end & (req_q.op == OP_READ);

  // State, phase counter, latched request and registered SRAM strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      req_q     <= '0;
      SRAM_ADDR <= '0;
      SRAM_WE_N <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      req_q     <= req_d;
      SRAM_ADDR <= addr_d;
      SRAM_WE_N <= we_n_d;
    end
  end

  // Next state, phase counting, request latch and ready
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_d     = req_q;
    bus.ready = 1'b0;
    unique case (state_q)
      IDLE: begin
        bus.ready = ~req_c;
        cnt_d     = '0;
        if (req_c) begin
          req_d.op   = bus.wr_en ? OP_WRITE : OP_READ;
          req_d.word = word_c;
          req_d.data = bus.write_data;
          state_d    = fwd_hit ? DONE : LO;
        end
      end
      LO, HI: begin
        if (phase_end) begin
          cnt_d   = '0;
          state_d = (state_q == LO) ? HI : DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        bus.ready = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // SRAM address/strobe/drive values for the upcoming cycle
  always_comb begin
    addr_d       = '0;
    we_n_d       = 1'b1;
    drive_en_d   = 1'b0;
    drive_data_d = '0;
    if ((state_d == LO) || (state_d == HI)) begin
      addr_d       = {req_d.word, (state_d == HI)};
      we_n_d       = (req_d.op != OP_WRITE);
      drive_en_d   = (req_d.op == OP_WRITE);
      drive_data_d = (state_d == HI) ? req_d.data[31:16] : req_d.data[15:0];
    end
  end

  sram_dq_io u_dq_io (
    .clk          (clk),
    .rst          (rst),
    .drive_en_d   (drive_en_d),
    .drive_data_d (drive_data_d),
    .cap_lo       (cap_lo),
    .cap_hi       (cap_hi),
    .fwd_load     (fwd_load),
    .fwd_data     (fwd_data),
    .read_data    (bus.read_data),
    .dq           (SRAM_DQ)
  );

endmodule

// File: tb/tb_sram_controller.sv
// Self-checking bench for sram_controller: word-level reference model plus an SRAM device model.
// Honours SRAM_CTRL_FORWARD_EN the same way the design does.
module tb_sram_controller;
  import sram_ctrl_pkg::*;

  localparam int unsigned BASE = DEF_BASE_ADDR;
  localparam int          P    = DEF_PHASE_CYCLES;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  wire  [15:0] sram_dq;
  logic [17:0] sram_addr;
  logic        ub_n, lb_n, ce_n, oe_n, we_n;

  sram_controller_if bus ();

  sram_controller #(.BASE_ADDR(BASE), .PHASE_CYCLES(P)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .SRAM_DQ   (sram_dq),
    .SRAM_ADDR (sram_addr),
    .SRAM_UB_N (ub_n),
    .SRAM_LB_N (lb_n),
    .SRAM_CE_N (ce_n),
    .SRAM_OE_N (oe_n),
    .SRAM_WE_N (we_n)
  );

  always #5 clk = ~clk;

  // SRAM device: registered read; a half-word commits once WE_N has been held low
  // at one address for two consecutive cycles (minimum write-pulse width)
  logic [15:0] sram_mem [0:(1<<18)-1];
  logic [15:0] sram_q = '0;
  logic [17:0] prev_addr = '0;
  logic        prev_we = 1'b0;

  assign sram_dq = we_n ? sram_q : 16'hzzzz;

  always @(posedge clk) begin
    sram_q    <= sram_mem[sram_addr];
    if (!we_n && prev_we && (sram_addr == prev_addr)) sram_mem[sram_addr] <= sram_dq;
    prev_we   <= !we_n;
    prev_addr <= sram_addr;
  end

  // Word-level reference model
  logic [31:0] ref_word [int unsigned];
  logic        m_fwd_valid = 1'b0;
  logic [16:0] m_fwd_word  = '0;
  logic [31:0] m_fwd_data  = '0;

  function automatic logic [31:0] ref_read(input logic [16:0] w);
    if (ref_word.exists(32'(w))) return ref_word[32'(w)];
    return 32'h0;
  endfunction

  // Per-cycle expectations, set by the driver and checked at the falling edge
  logic        exp_on = 1'b0;
  logic        exp_ready = 1'b1;
  logic        exp_we_n = 1'b1;
  logic [17:0] exp_addr = '0;
  logic        exp_drv = 1'b0;
  logic [15:0] exp_dq = '0;
  logic [31:0] exp_rd = '0;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_on) begin
      check("ready", 32'(bus.ready), 32'(exp_ready));
      check("sram_we_n", 32'(we_n), 32'(exp_we_n));
      check("sram_addr", 32'(sram_addr), 32'(exp_addr));
      check("sram_dq", 32'(sram_dq), exp_drv ? 32'(exp_dq) : 32'(sram_q));
      check("read_data", bus.read_data, exp_rd);
      check("tied_strobes", 32'({ub_n, lb_n, ce_n, oe_n}), 32'h0);
    end
  end

  // Length of the most recent run of ready-low cycles
  int stall_run = 0;
  int last_stall = 0;
  always @(negedge clk) begin
    if (rst) stall_run = 0;
    else if (!bus.ready) stall_run++;
    else if (stall_run != 0) begin
      last_stall = stall_run;
      stall_run  = 0;
    end
  end

  task automatic set_idle_exp();
    exp_on    = 1'b1;
    exp_ready = 1'b1;
    exp_we_n  = 1'b1;
    exp_addr  = '0;
    exp_drv   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      rst            = 1'b0;
      bus.wr_en      = 1'b0;
      bus.rd_en      = 1'b0;
      bus.address    = $urandom;
      bus.write_data = $urandom;
      set_idle_exp();
    end
  endtask

  task automatic do_reset(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      rst       = 1'b1;
      bus.wr_en = 1'b0;
      bus.rd_en = 1'b0;
      exp_on    = 1'b0;
    end
    exp_rd      = '0;
    m_fwd_valid = 1'b0;
  endtask

  // One access; abort_at >= 0 asserts rst during that cycle of the access
  task automatic access(input bit wr, input bit rd, input logic [31:0] addr,
                        input logic [31:0] wd, input int abort_at);
    logic [16:0] word;
    logic [31:0] old;
    logic        hi;
    bit          is_wr, is_rd, hit;
    int          len;
    word  = 17'((addr - 32'(BASE)) >> 2);
    is_wr = wr;
    is_rd = rd && !wr;
    hit   = 1'b0;
`ifdef SRAM_CTRL_FORWARD_EN
    hit = is_rd && m_fwd_valid && (m_fwd_word == word);
`endif
    len = hit ? 1 : 2 * P + 1;
    old = ref_read(word);
    for (int c = 0; c <= len; c++) begin
      @(posedge clk); #1;
      rst = (c == abort_at);
      if (c == 0) begin
        bus.wr_en      = wr;
        bus.rd_en      = rd;
        bus.address    = addr;
        bus.write_data = wd;
      end else if (c < len) begin
        bus.wr_en      = 1'($urandom_range(0, 1));
        bus.rd_en      = 1'($urandom_range(0, 1));
        bus.address    = $urandom;
        bus.write_data = $urandom;
      end else begin
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
      end
      set_idle_exp();
      exp_ready = (c == len);
      if ((c >= 1) && (c < len) && !hit) begin
        hi       = (c > P);
        exp_addr = {word, hi};
        exp_we_n = !is_wr;
        exp_drv  = is_wr;
        exp_dq   = hi ? wd[31:16] : wd[15:0];
      end
      if ((c == len) && is_rd) exp_rd = hit ? m_fwd_data : old;
      if (c == abort_at) begin
        if (is_wr && (c >= 2 * P)) ref_word[32'(word)] = wd;
        else if (is_wr && (c >= P)) ref_word[32'(word)] = {old[31:16], wd[15:0]};
        m_fwd_valid = 1'b0;
        @(negedge clk); #1;
        exp_rd = '0;
        return;
      end
    end
    if (is_wr) begin
      ref_word[32'(word)] = wd;
      m_fwd_valid = 1'b1;
      m_fwd_word  = word;
      m_fwd_data  = wd;
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << 18); i++) sram_mem[i] = 16'h0;
    bus.wr_en      = 1'b0;
    bus.rd_en      = 1'b0;
    bus.address    = '0;
    bus.write_data = '0;

    // Reset state
    do_reset(3);
    idle(1);
    #1;
    check("rst_ready", 32'(bus.ready), 32'h1);
    check("rst_we_n", 32'(we_n), 32'h1);
    check("rst_read_data", bus.read_data, 32'h0);
    check("rst_addr", 32'(sram_addr), 32'h0);

    // Store then load at the base address
    access(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, -1);
    idle(1);
    check("store_stall", 32'(last_stall), 32'd5);
    check("store_lo_half", 32'(sram_mem[0]), 32'h0000BEEF);
    check("store_hi_half", 32'(sram_mem[1]), 32'h0000DEAD);
    access(1'b0, 1'b1, 32'd1024, 32'h0, -1);
    check("load_data", bus.read_data, 32'hDEADBEEF);
    idle(1);
    check("load_stall", 32'(last_stall), 32'd5);

    // Simultaneous request: write wins
    access(1'b1, 1'b1, 32'd1032, 32'h12345678, -1);
    idle(1);
    check("both_lo_half", 32'(sram_mem[4]), 32'h00005678);
    check("both_hi_half", 32'(sram_mem[5]), 32'h00001234);
    access(1'b0, 1'b1, 32'd1032, 32'h0, -1);
    check("both_readback", bus.read_data, 32'h12345678);

    // Reset in the first HI cycle of a store
    access(1'b1, 1'b0, 32'd1032, 32'hAAAA5555, P + 1);
    idle(1);
    #1;
    check("abort_we_n", 32'(we_n), 32'h1);
    check("abort_read_data", bus.read_data, 32'h0);
    access(1'b0, 1'b1, 32'd1032, 32'h0, -1);
    check("abort_readback", bus.read_data, 32'h12345555);

    // Address below base wraps to the top of the SRAM
    access(1'b1, 1'b0, 32'd1020, 32'h0BADF00D, -1);
    idle(1);
    check("wrap_lo_half", 32'(sram_mem[18'h3FFFE]), 32'h0000F00D);
    access(1'b0, 1'b1, 32'd1020, 32'h0, -1);
    check("wrap_readback", bus.read_data, 32'h0BADF00D);

    // Read right after a store (forwarded when enabled)
    access(1'b1, 1'b0, 32'd1040, 32'hCAFEF00D, -1);
    access(1'b0, 1'b1, 32'd1040, 32'h0, -1);
    check("fwd_data", bus.read_data, 32'hCAFEF00D);
    idle(1);
`ifdef SRAM_CTRL_FORWARD_EN
    check("fwd_stall", 32'(last_stall), 32'd1);
`else
    check("fwd_stall", 32'(last_stall), 32'd5);
`endif
    access(1'b0, 1'b1, 32'd1044, 32'h0, -1);
    idle(1);
    check("fwd_miss_stall", 32'(last_stall), 32'd5);

    // Randomized traffic over a small window, including wrapped and unaligned addresses
    repeat (150) begin
      int          op;
      logic [31:0] a;
      op = int'($urandom_range(0, 2));
      if ($urandom_range(0, 7) == 0) a = 32'(BASE) - 32'(4 * $urandom_range(1, 3));
      else a = 32'(BASE) + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
      access(op != 1, op != 0, a, $urandom, -1);
      idle(int'($urandom_range(0, 2)));
    end

    idle(2);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    n_errors++;
    $display("FAIL watchdog: simulation did not finish, time %0t limit 1000000", $time);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/sram_controller.md
# sram_controller

Sequences 32-bit load/store requests from the ARM core's MEM stage onto the 16-bit external SRAM. Each word access is split into two half-word phases (low half, then high half). The block drives the SRAM control strobes, address and bidirectional data bus, and holds `ready` low so the pipeline freezes until the access completes. It sits between the MEM stage and the `sram` device model / board SRAM.

## Interface
Parameters:
- `BASE_ADDR`, default 1024: processor byte address that maps to SRAM half-word 0.
- `PHASE_CYCLES`, default 2: clock cycles spent on each half-word phase; must be ≥2.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `wr_en`  in  1  store request.
- `rd_en`  in  1  load request.
- `address`  in  32  byte address of the access.
- `write_data`  in  32  store data.
- `read_data`  out  32  load result; valid in the DONE cycle and held until the next read completes.
- `ready`  out  1  access complete / no access pending; the pipeline freezes while low.
- `SRAM_DQ`  inout  16  SRAM data bus.
- `SRAM_ADDR`  out  18  SRAM half-word address.
- `SRAM_UB_N`, `SRAM_LB_N`, `SRAM_CE_N`, `SRAM_OE_N`  out  1 each  tied to 0.
- `SRAM_WE_N`  out  1  write strobe, active-low.

## Operation
- FSM states: IDLE, LO, HI, DONE. A phase counter counts 0..PHASE_CYCLES-1.
- **IDLE**
  - With `wr_en|rd_en` set: latch the op, word address and `write_data`, then go to LO.
  - `ready` = ~(`wr_en|rd_en`), combinational.
- **LO and HI**
  - Each state lasts PHASE_CYCLES cycles, then advances LO→HI→DONE.
  - `ready` = 0.
- **DONE**
  - `ready` = 1 for exactly one cycle, then return to IDLE.
  - The requester advances on this cycle. A request still present in the following IDLE cycle is treated as a new access.
- **Address mapping:** word = (`address` − BASE_ADDR) >> 2, truncated to 17 bits. `SRAM_ADDR` is {word, 0} in LO and {word, 1} in HI. In IDLE/DONE, `SRAM_ADDR` = 0.
- **Write**
  - `SRAM_WE_N` = 0 for all cycles of LO and HI.
  - `SRAM_DQ` is driven with `write_data[15:0]` in LO and `write_data[31:16]` in HI.
- **Read**
  - `SRAM_WE_N` = 1 and `SRAM_DQ` = high-Z throughout.
  - `SRAM_DQ` is captured at the rising edge that ends the last cycle of LO (into the low half) and of HI (into the high half).
- **Priority:** if `wr_en` and `rd_en` are both set, the write wins.
- Request inputs are ignored outside IDLE; the latched copies are used.

## Timing
- **Reset values:** state IDLE, counter 0, `read_data` 0, `SRAM_WE_N` 1, `SRAM_DQ` high-Z, `SRAM_ADDR` 0.
- `ready` is 1 after reset when no request is present.
- **Latency:** for a request first seen at cycle 0, `ready` is low for cycles 0..2·PHASE_CYCLES and high at cycle 2·PHASE_CYCLES+1. With the default, that is 5 stall cycles, and DONE falls in cycle 5.
- Read data needs one registered SRAM cycle per phase; PHASE_CYCLES ≥2 guarantees it is stable at capture.
- **Reset mid-access:** abort immediately. The next cycle is IDLE with `SRAM_WE_N` = 1. A partially written word is not rolled back.
- **Address wrap:** addresses below BASE_ADDR wrap modulo 2^17 words. This is not an error.

## Configuration
- Macro `SRAM_CTRL_FORWARD_EN`.
- **Defined:** the block adds a last-write register holding `fwd_valid`, the word address and the data.
  - Every completed write updates it.
  - A read in IDLE whose word address matches while `fwd_valid` = 1 goes straight to DONE: `ready` is low for cycle 0 only, and `read_data` comes from the register.
  - Reset clears `fwd_valid`.
- **Undefined:** no register is present, and every read takes the full SRAM path.

## Structure
- **Package `sram_ctrl_pkg`:** state enum (IDLE, LO, HI, DONE), default BASE_ADDR/PHASE_CYCLES constants, SRAM address width (18) and data width (16).
- **Sub-module `sram_dq_io`:** tri-state driver for `SRAM_DQ` plus the half-word capture registers, enabled by the FSM phase and op.
- The FSM and counter stay in `sram_controller`.

## Test plan
- **Reset:** assert `rst` 3 cycles, no request → `SRAM_WE_N` = 1, `SRAM_DQ` = Z, `read_data` = 0, `ready` = 1.
- **Store:** store 0xDEADBEEF to 1024 → `SRAM_ADDR` 0 with DQ 0xBEEF for 2 cycles, then `SRAM_ADDR` 1 with DQ 0xDEAD for 2 cycles; `ready` low 5 cycles, then high 1.
- **Load after store:** with the model reset and the write above done, load 1024 → `read_data` = 0xDEADBEEF in the DONE cycle, 5 stall cycles; DQ never driven by the controller.
- **Simultaneous requests:** `wr_en` = `rd_en` = 1 at address 1032 with data 0x12345678 → a write to SRAM addresses 4/5; a later load of 1032 returns 0x12345678.
- **Reset mid-access:** `rst` asserted during HI of a store → IDLE next cycle, `SRAM_WE_N` = 1; a subsequent load of the same address returns the new low half and the old high half.
- **Forwarding:** with `SRAM_CTRL_FORWARD_EN`, store 0xCAFEF00D to 1040, then immediately load 1040 → `ready` low 1 cycle, `read_data` = 0xCAFEF00D; a load of 1044 takes 5 stall cycles.
